dff_bank_arbiter: RTL and testbench

DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

---
 rtl/dff_bank_arbiter_if.sv | 32 +++
 rtl/dff_bank_arbiter.sv | 105 ++++++++++
 tb/tb_dff_bank_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dff_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_arbiter_if
// Brief    : Request/grant/write bus between the requesters and the shared
//            register arbiter.
// Revision : 1.0
// ============================================================================
interface dff_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       Q;
    logic [2:0]             owner;
    logic                   busy;

    // Requester side.
    modport master (
        output req, wdata,
        input  gnt, ack, Q, owner, busy
    );

    // Arbiter side.
    modport slave (
        input  req, wdata,
        output gnt, ack, Q, owner, busy
    );
endinterface
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_arbiter
// Brief    : Round-robin arbiter granting N_REQ requesters write access to one
//            shared WIDTH-bit register, one three-cycle transfer at a time.
// Revision : 1.0
// ============================================================================
module dff_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dff_bank_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_ptr;
    logic [2:0]       r_winner;
    logic [7:0]       w_req_pad;
    logic             w_found;
    logic [3:0]       w_idx;
    logic [2:0]       w_next;
    logic [7:0]       w_next_oh;
    logic [7:0]       w_win_oh;
    logic [WIDTH-1:0] w_wsel;

    // Padding to 8 bits lets a fixed 3-bit index address any legal N_REQ.
    assign w_req_pad = 8'(bus.req);

    // Round-robin search starting one past the previous winner.
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= 4'(N_REQ))
                w_idx = w_idx - 4'(N_REQ);
            if (!w_found && w_req_pad[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_next  = w_idx[2:0];
            end
        end
    end

    assign w_next_oh = 8'd1 << w_next;
    assign w_win_oh  = 8'd1 << r_winner;

    always_comb begin
        w_wsel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_winner == 3'(i))
                w_wsel = bus.wdata[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_ptr    <= 3'(N_REQ - 1);
            r_winner <= '0;
            bus.gnt  <= '0;
            bus.ack  <= '0;
            bus.Q    <= '0;
            bus.owner <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_winner <= w_next;
                        bus.gnt  <= w_next_oh[N_REQ-1:0];
                        r_state  <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    // The transfer is committed: req is no longer consulted.
                    bus.Q     <= w_wsel;
                    bus.owner <= r_winner;
                    bus.ack   <= w_win_oh[N_REQ-1:0];
                    r_state   <= c_DONE;
                end
                c_DONE: begin
                    bus.gnt <= '0;
                    bus.ack <= '0;
                    r_ptr   <= r_winner;
                    r_state <= c_IDLE;
                end
                default: begin
                    bus.gnt <= '0;
                    bus.ack <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_bank_arbiter
// Brief    : Scoreboard bench for dff_bank_arbiter against a transaction-level
//            round-robin model; directed scenarios followed by random traffic.
// Revision : 1.0
// ============================================================================
module tb_dff_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        int         win;
        logic [W-1:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dff_bank_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    dff_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state, written only on negedges by the stimulus process.
    xfer_t        exp_q_fifo[$];
    int           cyc        = 0;
    int           next_arb   = 0;
    int           sample_at  = -1;
    int           m_ptr      = N - 1;
    int           m_win      = 0;
    logic [N-1:0] exp_gnt    = '0;
    logic [N-1:0] exp_ack    = '0;
    logic [W-1:0] exp_q      = '0;
    logic [2:0]   exp_owner  = '0;
    logic         mon_en     = 1'b0;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Predicts the outputs that follow the next rising edge from the inputs
    // just applied: a win at edge t samples data at t+1 and frees the bus at t+3.
    task automatic model_edge();
        xfer_t x;
        cyc++;
        exp_ack = '0;
        if (rst) begin
            m_ptr     = N - 1;
            next_arb  = cyc + 1;
            sample_at = -1;
            exp_gnt   = '0;
            exp_q     = '0;
            exp_owner = '0;
        end else if (cyc == sample_at) begin
            x.win     = m_win;
            x.data    = bus.wdata[m_win*W +: W];
            exp_q     = x.data;
            exp_owner = 3'(m_win);
            exp_ack   = onehot(m_win);
            exp_q_fifo.push_back(x);
        end else if (cyc >= next_arb && bus.req != '0) begin
            m_win     = rr_pick(m_ptr, bus.req);
            m_ptr     = m_win;
            sample_at = cyc + 1;
            next_arb  = cyc + 3;
            exp_gnt   = onehot(m_win);
        end else begin
            exp_gnt = '0;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] wd);
        @(negedge clk);
        rst       = r;
        bus.req   = rq;
        bus.wdata = wd;
        model_edge();
        mon_en = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req_v);
        end
    endtask

    // Monitor: compares every cycle, pops the scoreboard on each ack pulse.
    initial begin
        xfer_t x;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                check("gnt",   32'(bus.gnt),   32'(exp_gnt));
                check("ack",   32'(bus.ack),   32'(exp_ack));
                check("busy",  32'(bus.busy),  32'(exp_gnt != '0));
                check("Q",     32'(bus.Q),     32'(exp_q));
                check("owner", 32'(bus.owner), 32'(exp_owner));
                check("onehot_gnt", 32'($countones(bus.gnt) <= 1), 32'd1);
                check("ack_has_gnt", 32'((bus.ack & ~bus.gnt) == '0), 32'd1);
                if (bus.ack != '0) begin
                    if (exp_q_fifo.size() == 0) begin
                        check("sb_unexpected_ack", 32'(bus.ack), 32'd0);
                    end else begin
                        x = exp_q_fifo.pop_front();
                        check("sb_ack",   32'(bus.ack),   32'(onehot(x.win)));
                        check("sb_data",  32'(bus.Q),     32'(x.data));
                        check("sb_owner", 32'(bus.owner), 32'(x.win));
                    end
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] wd;
        bus.req   = '0;
        bus.wdata = '0;

        step(1, '0, '0);
        step(1, '0, '0);

        // Single request from requester 0.
        step(0, 4'b0001, 32'h0000_00A5);
        step(0, 4'b0000, 32'h0000_00A5);
        repeat (3) step(0, '0, '0);

        // All contend: expected order 0,1,2,3 -> last winner 3.
        step(1, '0, '0);
        repeat (12) step(0, 4'b1111, 32'h4433_2211);
        step(0, '0, 32'h4433_2211);
        step(0, '0, 32'h4433_2211);

        // Wrap-around after winner 3: 0 first, then 3.
        repeat (3) step(0, 4'b1001, 32'h9900_0077);
        repeat (3) step(0, 4'b1001, 32'h9900_0077);
        step(0, '0, '0);

        // Early drop: req falls in GRANT, wdata changes the same cycle.
        step(0, 4'b0100, 32'h0011_0000);
        step(0, 4'b0000, 32'h0055_0000);
        repeat (3) step(0, '0, 32'h00EE_0000);

        // Reset while granted: no ack, Q cleared.
        step(0, 4'b0010, 32'h0000_6600);
        step(1, 4'b0010, 32'h0000_6600);
        step(0, '0, '0);
        step(0, '0, '0);

        // Idle hold after a write.
        step(0, 4'b1000, 32'h3C00_0000);
        repeat (20) step(0, '0, '0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            wd = {$urandom, $urandom};
            step(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), wd[N*W-1:0]);
        end

        repeat (5) step(0, '0, '0);
        @(posedge clk);
        #2;
        check("sb_drained", 32'(exp_q_fifo.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
